// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx
//   Receive side of the TDM link. Takes one slot word per accepted cycle,
//   with slot 0 marked by frame_sync, and spreads the words across N
//   parallel channel outputs. Frame alignment is tracked by a HUNT/LOCKED
//   state machine. Incoming words collect in a shadow buffer, and ch_data
//   is only loaded once a complete, aligned frame has arrived.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         multiplexed slot word (W bits)
//   din_valid   din carries a slot word this cycle
//   frame_sync  din is slot 0 (qualified by din_valid)
//   ch_data     channel outputs, channel k at [k*W +: W]
//   frame_done  one-cycle pulse when ch_data takes a new frame
//   locked      high while frame alignment is held
//   sync_err    one-cycle pulse per alignment error
//   err_count   saturating count of sync_err pulses
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | not aligned; wait for a word flagged with frame_sync
// LOCKED | aligned; slot_q gives the slot number of the next word

module tdm_demux_rx #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [N*W-1:0] ch_data,
  output logic           frame_done,
  output logic           locked,
  output logic           sync_err,
  output logic [7:0]     err_count
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  slot_q, slot_d;
  logic [W-1:0]   shadow_q [N];
  logic [W-1:0]   shadow_d [N];
  logic           load_frame;
  logic           err_d;
  logic           slot_is_first;
  logic           slot_is_last;
  logic [N*W-1:0] frame_flat;

  assign slot_is_first = (slot_q == '0);
  assign slot_is_last  = (slot_q == CW'(N-1));

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow_d   = shadow_q;
    load_frame = 1'b0;
    err_d      = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            slot_d      = CW'(1);
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync == slot_is_first) begin
            for (int k = 0; k < N; k++) begin
              if (slot_q == CW'(k)) shadow_d[k] = din;
            end
            if (slot_is_last) begin
              slot_d     = '0;
              load_frame = 1'b1;
            end else begin
              slot_d = slot_q + CW'(1);
            end
          end else if (frame_sync) begin
            // Early sync: drop the partial frame and restart at slot 0
            // using this word. Alignment is kept.
            err_d       = 1'b1;
            shadow_d[0] = din;
            slot_d      = CW'(1);
          end else begin
            // Missing sync at slot 0: alignment is gone, so discard the word
            // and return to HUNT.
            err_d   = 1'b1;
            state_d = HUNT;
            slot_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // The last slot word goes into ch_data in the same edge that writes it
  // to the shadow buffer, so ch_data is loaded from the next-shadow value.
  always_comb begin
    frame_flat = '0;
    for (int k = 0; k < N; k++) begin
      frame_flat[k*W +: W] = shadow_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      for (int k = 0; k < N; k++) shadow_q[k] <= '0;
      ch_data    <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shadow_q   <= shadow_d;
      frame_done <= load_frame;
      sync_err   <= err_d;
      if (load_frame) ch_data <= frame_flat;
      if (err_d && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_rx.sv
module tb_tdm_demux_rx;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [N*W-1:0] ch_data;
  logic           frame_done;
  logic           locked;
  logic           sync_err;
  logic [7:0]     err_count;

  tdm_demux_rx #(.W(W), .N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .ch_data(ch_data), .frame_done(frame_done),
    .locked(locked), .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model. A frame is the list of words received since the last
  // sync. While aligned, an empty list means the next word must carry
  // frame_sync.
  bit             m_locked;
  logic [W-1:0]   m_frame[$];
  logic [N*W-1:0] m_ch;
  bit             m_done, m_err;
  int             m_cnt;

  int done_seen, err_seen;

  typedef struct {
    bit             v;
    bit             s;
    logic [W-1:0]   d;
    bit             done;
    bit             err;
    bit             lk;
    int             cnt;
    logic [N*W-1:0] ch;
  } vec_t;

  vec_t tbl[11];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_frame.delete();
    m_ch = '0;
    m_done = 0;
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic model_err();
    m_err = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  task automatic model_word(bit v, bit s, logic [W-1:0] d);
    m_done = 0;
    m_err  = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1;
        m_frame.delete();
        m_frame.push_back(d);
      end
    end else if (s) begin
      if (m_frame.size() != 0) model_err();
      m_frame.delete();
      m_frame.push_back(d);
    end else if (m_frame.size() == 0) begin
      model_err();
      m_locked = 0;
    end else begin
      m_frame.push_back(d);
      if (m_frame.size() == N) begin
        for (int k = 0; k < N; k++) m_ch[k*W +: W] = m_frame[k];
        m_done = 1;
        m_frame.delete();
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".ch_data"},    64'(ch_data),    64'(m_ch));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(m_done));
    check({tag, ".sync_err"},   64'(sync_err),   64'(m_err));
    check({tag, ".locked"},     64'(locked),     64'(m_locked));
    check({tag, ".err_count"},  64'(err_count),  64'(m_cnt));
  endtask

  // Called at a negedge. Drives one cycle of input, lets the DUT take the
  // rising edge, then compares the outputs at the following negedge.
  task automatic step(string tag, bit v, bit s, logic [W-1:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_word(v, s, d);
    @(negedge clk);
    check_all(tag);
    if (frame_done) done_seen++;
    if (sync_err)   err_seen++;
  endtask

  task automatic send_frame(string tag, logic [N*W-1:0] f);
    for (int k = 0; k < N; k++) step(tag, 1'b1, (k == 0), f[k*W +: W]);
  endtask

  initial begin
    // {v, s, d, done, err, locked, err_count, ch_data}
    tbl[0]  = '{1, 1, 8'h11, 0, 0, 1, 0, 32'h0};
    tbl[1]  = '{1, 0, 8'h22, 0, 0, 1, 0, 32'h0};
    tbl[2]  = '{1, 0, 8'h33, 0, 0, 1, 0, 32'h0};
    tbl[3]  = '{1, 0, 8'h44, 1, 0, 1, 0, 32'h44332211};
    tbl[4]  = '{0, 0, 8'h00, 0, 0, 1, 0, 32'h44332211};
    tbl[5]  = '{1, 1, 8'hAA, 0, 0, 1, 0, 32'h44332211};
    tbl[6]  = '{1, 0, 8'hBB, 0, 0, 1, 0, 32'h44332211};
    tbl[7]  = '{1, 1, 8'h01, 0, 1, 1, 1, 32'h44332211};
    tbl[8]  = '{1, 0, 8'h02, 0, 0, 1, 1, 32'h44332211};
    tbl[9]  = '{1, 0, 8'h03, 0, 0, 1, 1, 32'h44332211};
    tbl[10] = '{1, 0, 8'h04, 1, 0, 1, 1, 32'h04030201};

    rst_n = 1'b0;
    din_valid = 1'b0;
    frame_sync = 1'b0;
    din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'b0, '0);

    // Clean frame followed by early sync, checked against the table.
    for (int i = 0; i < 11; i++) begin
      step("tbl_model", tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("tbl[%0d].ch", i),     64'(ch_data),    64'(tbl[i].ch));
      check($sformatf("tbl[%0d].done", i),   64'(frame_done), 64'(tbl[i].done));
      check($sformatf("tbl[%0d].err", i),    64'(sync_err),   64'(tbl[i].err));
      check($sformatf("tbl[%0d].locked", i), 64'(locked),     64'(tbl[i].lk));
      check($sformatf("tbl[%0d].cnt", i),    64'(err_count),  64'(tbl[i].cnt));
    end

    // Gapped frame: 0..3 idle cycles after each word.
    done_seen = 0;
    err_seen  = 0;
    for (int k = 0; k < N; k++) begin
      step("gap", 1'b1, (k == 0), 8'(8'h11 * (k + 1)));
      repeat ($urandom_range(0, 3)) step("gap", 1'b0, 1'b0, 8'($urandom));
    end
    step("gap", 1'b0, 1'b0, '0);
    check("gap.ch", 64'(ch_data), 64'h44332211);
    check("gap.done_count", 64'(done_seen), 64'd1);
    check("gap.err_count", 64'(err_seen), 64'd0);

    // Missing sync: lose lock, ignore unsynced words, then relock.
    err_seen = 0;
    step("miss", 1'b1, 1'b0, 8'h55);
    check("miss.sync_err", 64'(sync_err), 64'd1);
    check("miss.locked", 64'(locked), 64'd0);
    step("miss", 1'b1, 1'b0, 8'h66);
    step("miss", 1'b1, 1'b0, 8'h77);
    check("miss.err_pulses", 64'(err_seen), 64'd1);
    send_frame("relock", 32'h04030201);
    check("relock.ch", 64'(ch_data), 64'h04030201);
    check("relock.locked", 64'(locked), 64'd1);

    // Saturation: each iteration ends on a missing-sync error.
    for (int i = 0; i < 300; i++) begin
      send_frame("sat", 32'($urandom));
      step("sat", 1'b1, 1'b0, 8'h5A);
    end
    check("sat.err_count", 64'(err_count), 64'd255);

    // Reset mid-frame, after two words of a new frame.
    send_frame("pre_rst", 32'hCAFEBABE);
    step("pre_rst", 1'b1, 1'b1, 8'h10);
    step("pre_rst", 1'b1, 1'b0, 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, 8'h33);
    send_frame("post_rst", 32'hD4C3B2A1);
    check("post_rst.ch", 64'(ch_data), 64'hD4C3B2A1);

    // Random traffic with gaps, stray syncs and missing syncs.
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive-side counterpart of the team's time-division multiplexer: takes the single multiplexed word stream (one word per slot, slot 0 flagged by a frame-sync strobe) and redistributes it to N parallel channel outputs.
- Tracks frame alignment with a HUNT/LOCKED state machine and double-buffers channel data so outputs change only on whole-frame boundaries.
- Sits between the serial/TDM link input and the per-channel consumers (display, LED, and register logic).

Parameters:
- W, 8, data width of one slot word.
- N, 4, slots per frame (number of output channels), 2..16.
- CW, 4, slot counter width; must satisfy 2^CW >= N.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  multiplexed slot word.
- din_valid  input  1  din holds a slot word this cycle.
- frame_sync  input  1  qualifies din as slot 0; ignored when din_valid=0.
- ch_data  output  N*W  channel outputs, channel k at bits [k*W +: W].
- frame_done  output  1  one-cycle pulse: ch_data just updated with a complete frame.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on each alignment error.
- err_count  output  8  saturating count of sync_err events.

Behaviour:
- Reset (async, rst_n=0):
  - state=HUNT, slot=0.
  - Shadow buffer and ch_data all zero.
  - frame_done=0, sync_err=0, locked=0, err_count=0.
- Accepted word: a cycle with din_valid=1; cycles with din_valid=0 change nothing (gaps of any length allowed).
- HUNT:
  - Words without frame_sync are discarded silently (no error).
  - din_valid & frame_sync: write din to shadow[0], slot<=1, go to LOCKED.
  - locked rises the cycle after the sync word.
- LOCKED, accepted word at slot s:
  - Expected: frame_sync = (s==0).
  - Match: shadow[s]<=din. If s==N-1, slot<=0; otherwise slot<=s+1.
  - Frame completion (match at s==N-1): next cycle ch_data<=shadow with din placed in slot N-1, and frame_done=1 for that cycle. Latency from last slot word to ch_data/frame_done is 1 clock.
  - frame_sync with s!=0 (early sync): sync_err pulse; partial frame discarded (ch_data unchanged, no frame_done); word taken as slot 0 (shadow[0]<=din, slot<=1); stay LOCKED.
  - No frame_sync with s==0 (missing sync): sync_err pulse; word discarded; go to HUNT, slot<=0, locked falls next cycle.
- err_count increments by 1 on each sync_err and holds at 255.
- Shadow entries not rewritten in a frame keep their old values. Only complete, aligned frames reach ch_data.
- N=2 minimum: sync word, then one word completes the frame.
- If rst_n asserts mid-frame, everything clears immediately (asynchronously), including any partial shadow contents. After release, the block restarts in HUNT.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: rst_n=0, then release with din_valid=0 -> ch_data=0, locked=0, frame_done=0, err_count=0 for 20 cycles.
- Clean frame (N=4, W=8): sync+0x11, 0x22, 0x33, 0x44 back-to-back -> one cycle after 0x44, ch_data=0x44332211 and frame_done pulses once; locked=1 from the cycle after 0x11.
- Gapped input: same frame with 0–3 idle cycles between words -> identical ch_data, exactly one frame_done, no sync_err.
- Early sync: sync+0xAA, 0xBB, then sync+0x01, 0x02, 0x03, 0x04 -> one sync_err at the second sync, err_count=1, no frame_done for the partial frame; after 0x04, ch_data=0x04030201.
- Missing sync: a complete frame, then 0x55 without sync at slot 0 -> sync_err, locked=0; then 0x66, 0x77 without sync are ignored with no further errors; then sync+0x01..0x04 -> relock, ch_data=0x04030201.
- Saturation and reset mid-frame: 300 missing-sync events -> err_count=255; assert rst_n after two words of a frame -> all outputs 0 immediately, and the next clean frame decodes correctly.
